// File: rtl/cover_pkg.sv
`default_nettype none
// cover_pkg: shared cover-index type and design-wide cover point total. | rev 1.0
package cover_pkg;
  localparam int COVER_IDX_W = 64;
  localparam int COVER_TOTAL = 38253;
  typedef logic [COVER_IDX_W-1:0] cover_idx_t;
endpackage
`default_nettype wire

// File: rtl/cover_toggle_drain_if.sv
`default_nettype none
// cover_toggle_drain_if: strobe/clear inputs and the index report stream. | rev 1.0
interface cover_toggle_drain_if
  import cover_pkg::*;
#(
  parameter int WIDTH = 36
);
  localparam int HC_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] valid;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  cover_idx_t       out_index;
  logic [HC_W-1:0]  hit_count;
  logic             all_covered;

  modport master (
    output valid, clear, out_ready,
    input  out_valid, out_index, hit_count, all_covered
  );

  modport slave (
    input  valid, clear, out_ready,
    output out_valid, out_index, hit_count, all_covered
  );
endinterface
`default_nettype wire

// File: rtl/cover_lsb_enc.sv
`default_nettype none
// cover_lsb_enc: lowest-set-bit finder returning any, binary index and one-hot mask. | rev 1.0
module cover_lsb_enc #(
  parameter  int WIDTH = 36,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any,
  output logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] taken
);
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

  assign any   = |vec;
  // Two's-complement isolate: keeps only the lowest set bit.
  assign taken = vec & (~vec + WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/cover_toggle_drain.sv
`default_nettype none
// cover_toggle_drain: sticky toggle bitmap drained as ascending cover indices, one per cycle.
// Macros: COVER_TOGGLE_COUNT_EN adds hit_count/all_covered; SYNTHESIS strips the block. | rev 1.0
module cover_toggle_drain
  import cover_pkg::*;
#(
  parameter int WIDTH       = 36,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL
) (
  input logic                 clock,
  input logic                 reset_n,
  cover_toggle_drain_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HC_W  = $clog2(WIDTH + 1);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover_toggle_drain: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

`ifndef SYNTHESIS
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] covered;
  logic [WIDTH-1:0] onehot;
  logic [WIDTH-1:0] taken;
  logic [IDX_W-1:0] lsb;
  logic             any;
  logic             fire;
  logic             load;
  logic             out_valid_q;
  cover_idx_t       out_index_q;

  cover_lsb_enc #(.WIDTH(WIDTH)) u_enc (
    .vec   (pending),
    .any   (any),
    .index (lsb),
    .taken (onehot)
  );

  assign fire  = out_valid_q & bus.out_ready;
  assign load  = any & (~out_valid_q | bus.out_ready);
  assign taken = load ? onehot : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      covered     <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else if (bus.clear) begin
      pending     <= '0;
      covered     <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      // A strobe landing on the bit being taken is dropped: it is covered from now on.
      pending <= (pending | (bus.valid & ~covered & ~pending)) & ~taken;
      covered <= covered | taken;
      if (load) begin
        out_valid_q <= 1'b1;
        out_index_q <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(lsb);
      end else if (fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_index_q;

`ifdef COVER_TOGGLE_COUNT_EN
  logic [HC_W-1:0] hit_q;
  logic [HC_W-1:0] hit_next;
  logic            all_q;

  always_comb begin
    hit_next = hit_q;
    if (fire && (hit_q != HC_W'(WIDTH))) hit_next = hit_q + HC_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_q <= '0;
      all_q <= 1'b0;
    end else if (bus.clear) begin
      hit_q <= '0;
      all_q <= 1'b0;
    end else begin
      hit_q <= hit_next;
      all_q <= (hit_next == HC_W'(WIDTH));
    end
  end

  assign bus.hit_count   = hit_q;
  assign bus.all_covered = all_q;
`else
  assign bus.hit_count   = '0;
  assign bus.all_covered = 1'b0;
`endif

`else
  assign bus.out_valid   = 1'b0;
  assign bus.out_index   = '0;
  assign bus.hit_count   = '0;
  assign bus.all_covered = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cover_toggle_drain.sv
`default_nettype none
// tb_cover_toggle_drain: directed and randomized checks of cover_toggle_drain (WIDTH=36, base 100).
module tb_cover_toggle_drain;
  import cover_pkg::*;

  localparam int W    = 36;
  localparam int BASE = 100;
`ifdef COVER_TOGGLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  cover_toggle_drain_if #(.WIDTH(W)) bus ();

  cover_toggle_drain #(.WIDTH(W), .COVER_INDEX(BASE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Reports observed in a window: index and cycle of each fire.
  cover_idx_t rep_idx[$];
  int         rep_cyc[$];

  function automatic int exp_hits(int n);
    return CNT_EN ? n : 0;
  endfunction

  function automatic logic [W-1:0] bitv(int i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_state();
    bus.valid = '0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_index !== '0) begin
      failures++;
      $display("FAIL reset_out: valid=%0b index=%0d, want 0/0", bus.out_valid, bus.out_index);
    end
    checks++;
    if (bus.hit_count !== '0 || bus.all_covered !== 1'b0) begin
      failures++;
      $display("FAIL reset_count: hit=%0d all=%0b, want 0/0", bus.hit_count, bus.all_covered);
    end
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int first = -1;
    int pulses = 0;
    cover_idx_t idx = '0;
    clear_state();
    bus.out_ready = 1'b1;
    bus.valid     = bitv(0);
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin
        pulses++;
        if (first < 0) begin first = c; idx = bus.out_index; end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (bus.hit_count !== exp_hits(c - 2)) begin
          failures++;
          $display("FAIL single_hit_c%0d: got %0d want %0d", c, bus.hit_count, exp_hits(c - 2));
        end
      end
      tick();
      bus.valid = '0;
    end
    checks++;
    if (first !== 2 || pulses !== 1) begin
      failures++;
      $display("FAIL single_timing: first=%0d pulses=%0d, want 2/1", first, pulses);
    end
    checks++;
    if (idx !== cover_idx_t'(BASE)) begin
      failures++;
      $display("FAIL single_index: got %0d want %0d", idx, BASE);
    end
  endtask

  task automatic collect(int ncyc, logic [W-1:0] pat, int hold);
    rep_idx.delete();
    rep_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      bus.valid = (c < hold) ? pat : '0;
      if (bus.out_valid && bus.out_ready) begin
        rep_idx.push_back(bus.out_index);
        rep_cyc.push_back(c);
      end
      tick();
    end
    bus.valid = '0;
  endtask

  task automatic test_multi();
    int exp_i[3] = '{100, 102, 135};
    clear_state();
    bus.out_ready = 1'b1;
    collect(14, 36'h8_0000_0005, 10);
    checks++;
    if (rep_idx.size() !== 3) begin
      failures++;
      $display("FAIL multi_count: got %0d want 3", rep_idx.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rep_idx[k] !== cover_idx_t'(exp_i[k]) || rep_cyc[k] !== 2 + k) begin
          failures++;
          $display("FAIL multi_rep%0d: idx=%0d cyc=%0d want idx=%0d cyc=%0d",
                   k, rep_idx[k], rep_cyc[k], exp_i[k], 2 + k);
        end
      end
    end
    checks++;
    if (bus.hit_count !== exp_hits(3) || bus.all_covered !== 1'b0) begin
      failures++;
      $display("FAIL multi_hit: hit=%0d all=%0b want %0d/0", bus.hit_count, bus.all_covered, exp_hits(3));
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_state();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.valid = (c == 0) ? bitv(3) : (c == 5) ? bitv(7) : '0;
      if (c >= 2 && (bus.out_valid !== 1'b1 || bus.out_index !== cover_idx_t'(103))) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold: %0d cycles without valid 103, want 0", bad);
    end
    bus.out_ready = 1'b1;
    collect(6, '0, 0);
    checks++;
    if (rep_idx.size() !== 2) begin
      failures++;
      $display("FAIL bp_count: got %0d want 2", rep_idx.size());
    end else begin
      checks++;
      if (rep_idx[0] !== cover_idx_t'(103) || rep_idx[1] !== cover_idx_t'(107) || rep_cyc[1] !== rep_cyc[0] + 1) begin
        failures++;
        $display("FAIL bp_order: got %0d,%0d want 103,107 back to back", rep_idx[0], rep_idx[1]);
      end
    end
  endtask

  task automatic test_collision();
    clear_state();
    bus.out_ready = 1'b1;
    rep_idx.delete();
    for (int c = 0; c < 10; c++) begin
      bus.valid = (c == 0 || c == 1 || c == 6) ? bitv(5) : '0;
      if (bus.out_valid) rep_idx.push_back(bus.out_index);
      tick();
    end
    bus.valid = '0;
    checks++;
    if (rep_idx.size() !== 1 || rep_idx[0] !== cover_idx_t'(105)) begin
      failures++;
      $display("FAIL collision: %0d reports (first %0d), want one report of 105",
               rep_idx.size(), (rep_idx.size() > 0) ? rep_idx[0] : 0);
    end
  endtask

  task automatic test_all_and_clear();
    int bad = 0;
    clear_state();
    bus.out_ready = 1'b1;
    collect(45, '1, 1);
    checks++;
    if (rep_idx.size() !== W) begin
      failures++;
      $display("FAIL all_count: got %0d want %0d", rep_idx.size(), W);
    end else begin
      for (int k = 0; k < W; k++)
        if (rep_idx[k] !== cover_idx_t'(BASE + k) || rep_cyc[k] !== 2 + k) bad++;
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL all_seq: %0d out-of-sequence reports, want 0", bad);
      end
    end
    checks++;
    if (bus.hit_count !== exp_hits(W) || bus.all_covered !== CNT_EN) begin
      failures++;
      $display("FAIL all_covered: hit=%0d all=%0b want %0d/%0b", bus.hit_count, bus.all_covered, exp_hits(W), CNT_EN);
    end
    // Park an unfired report in the slot, then clear with a strobe in the clear cycle.
    clear_state();
    bus.out_ready = 1'b0;
    bus.valid     = bitv(4);
    tick();
    bus.valid = '0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== cover_idx_t'(104)) begin
      failures++;
      $display("FAIL clr_setup: valid=%0b index=%0d want 1/104", bus.out_valid, bus.out_index);
    end
    bus.clear = 1'b1;
    bus.valid = bitv(6);
    tick();
    bus.clear = 1'b0;
    bus.valid = '0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.hit_count !== '0 || bus.all_covered !== 1'b0) begin
      failures++;
      $display("FAIL clr_state: valid=%0b hit=%0d all=%0b want 0/0/0", bus.out_valid, bus.hit_count, bus.all_covered);
    end
    bus.out_ready = 1'b1;
    collect(8, bitv(0), 1);
    checks++;
    if (rep_idx.size() !== 1 || rep_idx[0] !== cover_idx_t'(BASE)) begin
      failures++;
      $display("FAIL clr_rereport: %0d reports (first %0d), want one report of 100",
               rep_idx.size(), (rep_idx.size() > 0) ? rep_idx[0] : 0);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    clear_state();
    bus.out_ready = 1'b1;
    bus.valid     = bitv(1) | bitv(3) | bitv(9) | bitv(20);
    tick();
    bus.valid = '0;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== cover_idx_t'(109) || bus.hit_count !== exp_hits(2)) begin
      failures++;
      $display("FAIL ar_setup: valid=%0b index=%0d hit=%0d want 1/109/%0d",
               bus.out_valid, bus.out_index, bus.hit_count, exp_hits(2));
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_index !== '0 || bus.hit_count !== '0 || bus.all_covered !== 1'b0) begin
      failures++;
      $display("FAIL ar_async: valid=%0b index=%0d hit=%0d all=%0b want all 0",
               bus.out_valid, bus.out_index, bus.hit_count, bus.all_covered);
    end
    tick();
    #2 reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL ar_quiet: %0d cycles with out_valid after reset, want 0", bad);
    end
    collect(6, bitv(1), 1);
    checks++;
    if (rep_idx.size() !== 1 || rep_idx[0] !== cover_idx_t'(101)) begin
      failures++;
      $display("FAIL ar_rereport: %0d reports, want one report of 101", rep_idx.size());
    end
  endtask

  task automatic test_random();
    bit         seen[W];
    bit         rep[W];
    int         nrep = 0;
    int         bad_fire = 0, bad_hold = 0, bad_hit = 0, bad_done = 0;
    bit         prev_stall = 1'b0;
    cover_idx_t prev_idx = '0;
    logic [W-1:0] v;
    int         k;
    clear_state();
    for (int b = 0; b < W; b++) begin seen[b] = 1'b0; rep[b] = 1'b0; end
    for (int c = 0; c < 400 + W + 4; c++) begin
      v = '0;
      if (c < 400) begin
        for (int b = 0; b < W; b++) if ($urandom_range(0, 15) == 0) v[b] = 1'b1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.valid = v;
      for (int b = 0; b < W; b++) if (v[b]) seen[b] = 1'b1;
      if (bus.hit_count !== exp_hits(nrep)) bad_hit++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_index !== prev_idx)) bad_hold++;
      if (bus.out_valid && bus.out_ready) begin
        k = int'(bus.out_index) - BASE;
        if (k < 0 || k >= W) bad_fire++;
        else if (!seen[k] || rep[k]) bad_fire++;
        else begin rep[k] = 1'b1; nrep++; end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_idx   = bus.out_index;
      tick();
    end
    bus.valid = '0;
    for (int b = 0; b < W; b++) if (seen[b] != rep[b]) bad_done++;
    checks++;
    if (bad_fire !== 0 || bad_hold !== 0) begin
      failures++;
      $display("FAIL rand_stream: bad_fire=%0d bad_hold=%0d want 0/0", bad_fire, bad_hold);
    end
    checks++;
    if (bad_done !== 0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: unreported=%0d out_valid=%0b want 0/0", bad_done, bus.out_valid);
    end
    checks++;
    if (bad_hit !== 0 || bus.hit_count !== exp_hits(nrep) || bus.all_covered !== (CNT_EN && nrep == W)) begin
      failures++;
      $display("FAIL rand_count: bad_hit=%0d hit=%0d all=%0b want 0/%0d/%0b",
               bad_hit, bus.hit_count, bus.all_covered, exp_hits(nrep), (CNT_EN && nrep == W));
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.valid     = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_collision();
    test_all_and_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cover_toggle_drain.md
# cover_toggle_drain

Parametrised toggle-coverage collector and drain for one instrumented signal group. Per-bit toggle strobes are captured into a sticky bitmap and deduplicated. Each point is emitted exactly once, in ascending order, as a global cover index on a valid/ready stream. The stream feeds the coverage sink (DPI bridge or formal monitor), so a burst of simultaneous toggles never needs more than one report per cycle.

## Interface
Parameters:
- WIDTH, 36, number of toggle points in this group (1..1024)
- COVER_INDEX, 0, global index of bit 0 of this group
- COVER_TOTAL, 38253, total cover points design-wide; used only for elaboration check COVER_INDEX+WIDTH <= COVER_TOTAL

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid  in  WIDTH  toggle strobes; bit i high = point i toggled this cycle
- clear  in  1  synchronous; forget all coverage state
- out_valid  out  1  out_index holds an unreported point
- out_ready  in  1  sink accepts; fire = out_valid & out_ready
- out_index  out  64  global index COVER_INDEX + i
- hit_count  out  $clog2(WIDTH+1)  distinct points reported so far
- all_covered  out  1  hit_count == WIDTH

## Operation
- Reset values: all outputs are 0. Bitmaps `pending` and `covered` are cleared.
- Capture: `pending <= (pending | (valid & ~covered & ~pending)) & ~taken`.
  - Bits already covered or already pending are ignored, so each point is reported at most once.
- Load: when the output slot is empty or fires, the lowest set bit of `pending` moves to the output register. That bit is `taken`: it is cleared from pending and set in covered in the same cycle.
- Output register:
  - out_valid and out_index are stable while out_valid & !out_ready.
  - out_valid falls only on fire with pending empty, or on clear.
- Ordering: ascending bit index among the pending bits at load time. A lower bit that arrives later can pass higher bits still pending.
- clear:
  - Next cycle, pending, covered, hit_count and out_valid are all 0.
  - An unfired output is discarded; this is the only case where out_valid drops without a fire.
  - valid in the clear cycle is ignored.
- Simultaneous events:
  - If valid[i] is high in the same cycle that bit i is taken, it is dropped, because i is now covered.
  - If fire and load happen in the same cycle, out_valid stays high with the new index (back-to-back, one report per cycle).
- Reset mid-operation: asynchronous. All state returns to reset values immediately, and in-flight reports are lost.

## Timing
- valid[i] in cycle n sets pending in cycle n+1. out_valid with that index appears in cycle n+2, given the slot is empty and i is the lowest pending bit.
- Sustained throughput: one index per cycle while out_ready is high.
- Worst-case drain: WIDTH cycles after the last strobe, with out_ready held high.
- hit_count increments in the cycle after fire, saturating at WIDTH. all_covered is registered in the same cycle as hit_count.
- Backpressure: with out_ready low, pending keeps accumulating and nothing is lost.

## Configuration
- COVER_TOGGLE_COUNT_EN defined:
  - The hit_count counter and the all_covered register are implemented.
- COVER_TOGGLE_COUNT_EN undefined:
  - hit_count is tied to 0 and all_covered is tied to 0; no counter flops exist.
  - Drain behaviour is identical in both builds.
- Whole block is excluded under SYNTHESIS, as for all coverage instrumentation.

## Structure
- Shared package `cover_pkg`:
  - COVER_IDX_W = 64
  - `typedef logic [COVER_IDX_W-1:0] cover_idx_t`
  - COVER_TOTAL localparam, shared by all groups
- Sub-module `cover_lsb_enc`:
  - Parametrised by WIDTH.
  - Outputs `any` and the lowest-set-bit index (`$clog2(WIDTH)` bits).
  - Also outputs the one-hot `taken` mask.

## Test plan
- WIDTH=36, COVER_INDEX=100, out_ready=1; valid=36'h1 for 1 cycle -> out_valid in cycle n+2 with out_index=100, a single pulse; hit_count=1 one cycle after the fire.
- valid=36'h8_0000_0005 held for 10 cycles with out_ready=1 -> exactly three reports, 100, 102 then 135, on consecutive cycles; later strobes are ignored and hit_count=3.
- out_ready=0 for 20 cycles while valid sets bits 7 and 3 in different cycles, then out_ready=1 -> out_index held at its first value, then 103, 107; no loss, no duplicates.
- Bit 5 strobed in exactly the cycle it is taken -> no second report of 105.
- All 36 bits strobed once, out_ready=1 -> 36 consecutive reports 100..135 and all_covered=1; then clear with out_valid high -> next cycle out_valid=0 and hit_count=0; bit 0 strobed again -> reported again as 100.
- reset_n low asynchronously while out_valid=1 mid-drain -> all outputs are 0 before the next clock edge; after release, nothing is reported until a new strobe arrives.
